// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, fetches words over a req/ready
// handshake and presents instr/pc/pc_plus4 to decode, honouring redirects and stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    typedef enum logic [1:0] {BOOT, FETCH, VALID} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] pend_target;
    logic        drop;
    logic [31:0] redirect_pc;

    assign redirect_pc = redirect_target & ~32'h0000_0003;

    // A response is only accepted when no redirect is pending or arriving with it.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   if (imem_ready && !drop && !redirect) state_next = VALID;
            VALID:   if (redirect || !stall) state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            pend_target <= RESET_PC;
            drop        <= 1'b0;
            instr       <= NOP_INSTR;
            pc          <= RESET_PC;
            pc_plus4    <= RESET_PC + 32'd4;
        end else begin
            state <= state_next;
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            fetch_pc <= redirect_pc;
                            drop     <= 1'b0;
                        end else if (drop) begin
                            fetch_pc <= pend_target;
                            drop     <= 1'b0;
                        end else begin
                            instr    <= imem_rdata;
                            pc       <= fetch_pc;
                            pc_plus4 <= fetch_pc + 32'd4;
                        end
                    end else if (redirect) begin
                        // Request cannot be aborted; remember where to go once it returns.
                        drop        <= 1'b1;
                        pend_target <= redirect_pc;
                    end
                end
                VALID: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        instr    <= NOP_INSTR;
                    end else if (!stall) begin
                        fetch_pc <= pc_plus4;
                        instr    <= NOP_INSTR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = fetch_pc;
    assign instr_valid = (state == VALID);
    // Forcing opcode to zero steers the control unit into its inert default case.
    assign opcode      = instr_valid ? instr[6:0] : 7'b000_0000;

endmodule
